// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: state encoding, default parameters and sizing helper for seq_lock_ctrl
package seq_lock_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        UNLOCKED = 3'd2,
        FAILED   = 3'd3,
        LOCKOUT  = 3'd4
    } lock_state_t;
    localparam int DEF_PAT_W = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1010;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_MAX_FAIL = 3;
    localparam int DEF_LOCK_CYCLES = 32;
    localparam int DEF_TIMEOUT = 16;
    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/seq_lock_ctrl_if.sv
// seq_lock_ctrl_if: button-entry strobes towards the lock, indicator and status lines back
interface seq_lock_ctrl_if;
    logic       i_bit_valid;
    logic       i_bit;
    logic       i_clear;
    logic       o_unlock;
    logic       o_fail;
    logic       o_locked;
    logic       o_busy;
    logic [1:0] o_fail_cnt;
    modport master (
        output i_bit_valid, i_bit, i_clear,
        input  o_unlock, o_fail, o_locked, o_busy, o_fail_cnt
    );
    modport slave (
        input  i_bit_valid, i_bit, i_clear,
        output o_unlock, o_fail, o_locked, o_busy, o_fail_cnt
    );
endinterface

// File: rtl/seq_lock_ctrl_timer.sv
// seq_timer: loadable down-counter; o_done flags the final cycle of a loaded interval
module seq_timer #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);
    logic [W-1:0] count;
    // reload on request, otherwise run down to zero and park there
    always_ff @(posedge i_clock) begin
        if (i_reset)
            count <= '0;
        else
            count <= i_load ? i_value : (count != '0 ? count - 1'b1 : count);
    end
    assign o_done = count == W'(1);
endmodule

// File: rtl/seq_lock_ctrl.sv
// seq_lock_ctrl: bit-serial combination lock with timed indicators and lockout; define SEQ_LOCK_TIMEOUT_EN to abandon stalled entries
module seq_lock_ctrl
    import seq_lock_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN     = PAT_W'(DEF_PATTERN),
    parameter int               HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int               MAX_FAIL    = DEF_MAX_FAIL,
    parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int               TIMEOUT     = DEF_TIMEOUT
) (
    input logic           i_clock,
    input logic           i_reset,
    seq_lock_ctrl_if.slave bus
);
    localparam int TW = $clog2(max3(HOLD_CYCLES, LOCK_CYCLES, TIMEOUT)) + 1;
    localparam int CW = $clog2(PAT_W + 1);
    lock_state_t    state;
    logic [PAT_W-2:0] code;
    logic [CW-1:0]  count;
    logic [1:0]     fail_cnt;
    logic           complete;
    logic           match;
    logic           lock_now;
    logic           tmr_load;
    logic           tmr_done;
    logic [TW-1:0]  tmr_value;
    // spot the strobe that completes the code and pick what the shared timer measures next
    always_comb begin
        complete = state == COLLECT && bus.i_bit_valid && !bus.i_clear && count == CW'(PAT_W - 1);
        match = {code, bus.i_bit} == PATTERN;
        lock_now = fail_cnt + 2'd1 == 2'(MAX_FAIL);
`ifdef SEQ_LOCK_TIMEOUT_EN
        tmr_load = bus.i_bit_valid && (state == IDLE || (state == COLLECT && !bus.i_clear));
        tmr_value = !complete ? TW'(TIMEOUT) : (!match && lock_now ? TW'(LOCK_CYCLES) : TW'(HOLD_CYCLES));
`else
        tmr_load = complete;
        tmr_value = !match && lock_now ? TW'(LOCK_CYCLES) : TW'(HOLD_CYCLES);
`endif
    end
    // entry sequencing, evaluation, timed holds and lockout
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            code <= '0;
            count <= '0;
            fail_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.i_bit_valid) begin
                    state <= COLLECT;
                    code <= (PAT_W-1)'(bus.i_bit);
                    count <= CW'(1);
                end
                COLLECT: if (bus.i_clear) begin
                    state <= IDLE;
                    code <= '0;
                    count <= '0;
                end else if (complete) begin
                    state <= match ? UNLOCKED : (lock_now ? LOCKOUT : FAILED);
                    fail_cnt <= match ? 2'd0 : fail_cnt + 2'd1;
                    code <= '0;
                    count <= '0;
                end else if (bus.i_bit_valid) begin
                    code <= (PAT_W-1)'({code, bus.i_bit});
                    count <= count + 1'b1;
                end
`ifdef SEQ_LOCK_TIMEOUT_EN
                else if (tmr_done) begin
                    state <= IDLE;
                    code <= '0;
                    count <= '0;
                end
`endif
                UNLOCKED, FAILED: if (bus.i_clear || tmr_done) state <= IDLE;
                LOCKOUT: if (tmr_done) begin
                    state <= IDLE;
                    fail_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    seq_timer #(.W(TW)) u_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (tmr_load),
        .i_value (tmr_value),
        .o_done  (tmr_done)
    );
    assign bus.o_unlock = state == UNLOCKED;
    assign bus.o_fail = state == FAILED;
    assign bus.o_locked = state == LOCKOUT;
    assign bus.o_busy = state != IDLE;
    assign bus.o_fail_cnt = fail_cnt;
endmodule

// File: tb/tb_seq_lock_ctrl.sv
// tb_seq_lock_ctrl: scenario tasks plus random traffic checked against a queue-based lock model
module tb_seq_lock_ctrl;
    localparam int PW = 4;
    localparam logic [PW-1:0] PAT = 4'b1010;
    localparam int HOLD = 8;
    localparam int MAXF = 3;
    localparam int LOCK = 32;
    localparam int TMO = 16;
`ifdef SEQ_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic i_clock = 1'b0;
    logic i_reset;
    int checks = 0;
    int fails = 0;
    logic [3:0] stim[$];
    int m_mode = 0;
    int m_left = 0;
    int m_fails = 0;
    int m_idle = 0;
    bit m_q[$];

    seq_lock_ctrl_if lif();

    seq_lock_ctrl #(
        .PAT_W(PW), .PATTERN(PAT), .HOLD_CYCLES(HOLD),
        .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK), .TIMEOUT(TMO)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (lif)
    );

    always #5 i_clock = ~i_clock;

    // mode: 0 idle, 1 entering, 2 unlocked, 3 failed, 4 locked out
    function automatic void model_step(input logic r, input logic c, input logic v, input logic b);
        int val;
        val = 0;
        if (r) begin
            m_mode = 0; m_left = 0; m_fails = 0; m_idle = 0; m_q.delete();
            return;
        end
        case (m_mode)
            0: begin
                if (v) begin
                    m_q.delete(); m_q.push_back(b); m_idle = 0; m_mode = 1;
                end
            end
            1: begin
                if (c) begin
                    m_mode = 0; m_q.delete();
                end else if (v) begin
                    m_q.push_back(b);
                    m_idle = 0;
                    if (m_q.size() == PW) begin
                        foreach (m_q[k]) val = val * 2 + int'(m_q[k]);
                        m_q.delete();
                        if (val == int'(PAT)) begin
                            m_mode = 2; m_left = HOLD; m_fails = 0;
                        end else begin
                            m_fails++;
                            m_mode = (m_fails == MAXF) ? 4 : 3;
                            m_left = (m_fails == MAXF) ? LOCK : HOLD;
                        end
                    end
                end else if (TO_EN) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_mode = 0; m_q.delete();
                    end
                end
            end
            2, 3: begin
                if (c) m_mode = 0;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0; m_fails = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [5:0] model_out();
        return {m_mode == 2, m_mode == 3, m_mode == 4, m_mode != 0, 2'(m_fails)};
    endfunction

    function automatic logic [5:0] dut_out();
        return {lif.o_unlock, lif.o_fail, lif.o_locked, lif.o_busy, lif.o_fail_cnt};
    endfunction

    function automatic void add_code(input logic [7:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back({3'b001, code[i]});
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) stim.push_back(4'b0000);
    endfunction

    task automatic step(input logic [3:0] s);
        {i_reset, lif.i_clear, lif.i_bit_valid, lif.i_bit} = s;
        @(posedge i_clock);
        model_step(s[3], s[2], s[1], s[0]);
        #1;
    endtask

    task automatic test_reset();
        stim.delete();
        stim.push_back(4'b1000); stim.push_back(4'b1000); stim.push_back(4'b1000);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL reset cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (dut_out() !== 6'b0) begin
            fails++;
            $display("FAIL reset_values: got %b want %b", dut_out(), 6'b0);
        end
    endtask

    task automatic test_unlock();
        int ucnt;
        ucnt = 0;
        stim.delete();
        add_code(8'(PAT), PW);
        add_idle(HOLD + 4);
        foreach (stim[i]) begin
            step(stim[i]);
            if (lif.o_unlock) ucnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL unlock cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ucnt != HOLD) begin
            fails++;
            $display("FAIL unlock_len: got %0d want %0d", ucnt, HOLD);
        end
        checks++;
        if (lif.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL unlock_busy_end: got %b want 0", lif.o_busy);
        end
    endtask

    task automatic test_fail_then_unlock();
        int ucnt;
        ucnt = 0;
        stim.delete();
        add_code(8'b0000, PW);
        add_idle(HOLD + 2);
        add_code(8'(PAT), PW);
        add_idle(HOLD + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            if (lif.o_unlock) ucnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL fail_unlock cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ucnt != HOLD || lif.o_fail_cnt !== 2'd0) begin
            fails++;
            $display("FAIL fail_unlock_end: got len %0d cnt %0d want len %0d cnt 0", ucnt, lif.o_fail_cnt, HOLD);
        end
    endtask

    task automatic test_lockout();
        int lcnt;
        int fcnt;
        lcnt = 0;
        fcnt = 0;
        stim.delete();
        for (int k = 0; k < MAXF; k++) begin
            add_code(8'b1111, PW);
            if (k < MAXF - 1) add_idle(HOLD + 2);
        end
        add_code(8'(PAT), PW);
        add_idle(LOCK);
        foreach (stim[i]) begin
            step(stim[i]);
            if (lif.o_locked) lcnt++;
            if (lif.o_fail) fcnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL lockout cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (lcnt != LOCK || fcnt != (MAXF - 1) * HOLD) begin
            fails++;
            $display("FAIL lockout_len: got locked %0d fail %0d want %0d %0d", lcnt, fcnt, LOCK, (MAXF - 1) * HOLD);
        end
        checks++;
        if (lif.o_fail_cnt !== 2'd0 || lif.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL lockout_end: got cnt %0d busy %b want 0 0", lif.o_fail_cnt, lif.o_busy);
        end
    endtask

    task automatic test_clear();
        int ucnt;
        ucnt = 0;
        stim.delete();
        add_code(8'b10, 2);
        stim.push_back(4'b0111);
        add_code(8'(PAT), PW);
        add_idle(HOLD + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            if (lif.o_unlock) ucnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL clear cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ucnt != HOLD) begin
            fails++;
            $display("FAIL clear_unlock_len: got %0d want %0d", ucnt, HOLD);
        end
    endtask

    task automatic test_collect_idle();
        int ucnt;
        ucnt = 0;
        stim.delete();
        add_code(8'b10, 2);
        add_idle(TMO + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL idle_collect cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (lif.o_busy !== !TO_EN || lif.o_fail_cnt !== 2'd0) begin
            fails++;
            $display("FAIL idle_collect_end: got busy %b cnt %0d want busy %b cnt 0", lif.o_busy, lif.o_fail_cnt, !TO_EN);
        end
        stim.delete();
        stim.push_back(4'b0100);
        add_code(8'(PAT), PW);
        add_idle(HOLD + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            if (lif.o_unlock) ucnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL idle_recover cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
        end
        checks++;
        if (ucnt != HOLD) begin
            fails++;
            $display("FAIL idle_recover_len: got %0d want %0d", ucnt, HOLD);
        end
    endtask

    task automatic test_reset_mid();
        stim.delete();
        add_code(8'(PAT), PW);
        add_idle(3);
        stim.push_back(4'b1000);
        add_idle(1);
        add_code(8'b10, 2);
        stim.push_back(4'b1000);
        add_code(8'(PAT), PW);
        add_idle(HOLD + 2);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, dut_out(), model_out());
            end
            if (stim[i][3]) begin
                checks++;
                if (dut_out() !== 6'b0) begin
                    fails++;
                    $display("FAIL reset_mid_zero cyc %0d: got %b want 000000", i, dut_out());
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        stim.delete();
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0: add_code(8'(PAT), PW);
                1: add_code(8'($urandom), PW);
                default: begin
                    n = $urandom_range(1, 20);
                    for (int j = 0; j < n; j++)
                        stim.push_back({1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 14) == 0),
                                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
                end
            endcase
        end
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (dut_out() !== model_out()) begin
                fails++;
                $display("FAIL random cyc %0d: stim %b got %b want %b", i, stim[i], dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_fail_then_unlock();
        test_lockout();
        test_clear();
        test_collect_idle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
